// File: rtl/line_fill_responder_pkg.sv
// rtl/line_fill_responder_pkg.sv - shared types and constants for the line fill responder
//
// Holds the fill FSM state encoding and the line/index widths used by
// line_fill_responder and line_assembler.
package line_fill_responder_pkg;

    localparam int LINE_BITS  = 512;
    localparam int LINE_IDX_W = 18;
    localparam int SET_IDX_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/line_fill_responder_assembler.sv
// rtl/line_fill_responder_assembler.sv - word-insert line register and returned-beat counter
//
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   clear        restart assembly of a new line (beat counter to 0)
//   word_valid   a returned read word is present on word
//   word         32-bit returned read word
//   line_next    line register with the current word inserted (combinational)
//   last_word    word_valid on the final beat of the line
module line_assembler
    import line_fill_responder_pkg::*;
#(
    parameter int LINE_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 word_valid,
    input  logic [31:0]          word,
    output logic [LINE_BITS-1:0] line_next,
    output logic                 last_word
);

    localparam int BEAT_W = $clog2(LINE_WORDS);

    logic [LINE_BITS-1:0] line_q;
    logic [BEAT_W-1:0]    beat_q;

    // Reads return in order, so the k-th returned word lands in slot k.
    always_comb begin
        line_next = line_q;
        if (word_valid) begin
            line_next[{beat_q, 5'b0} +: 32] = word;
        end
    end

    assign last_word = word_valid && (beat_q == BEAT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            line_q <= '0;
            beat_q <= '0;
        end else if (clear) begin
            beat_q <= '0;
        end else if (word_valid) begin
            line_q <= line_next;
            beat_q <= beat_q + 1'b1;
        end
    end

endmodule

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - cache line fill responder with optional write-back drain
//
// Serves program/data line fill requests from a word-wide backing memory with
// up to MAX_OUTSTANDING pipelined reads, and returns the 512-bit line with a
// one-cycle valid pulse. Build macro LINE_FILL_WB_DRAIN_EN adds the WB state,
// which drains the write-back FIFO ahead of any fill.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   is_req_f_prog/is_req_f_data     level fill requests
//   req_addr_f_prog/req_addr_f_data 18-bit line indices
//   read_*_data/read_*_addr         returned line and its set index (held)
//   prog_valid/data_valid           one-cycle return pulses
//   fifo_empty, write_back_addr/data, fifo_pop   write-back FIFO side
//   mem_req/we/addr/wdata/ready/rvalid/rdata     backing memory side
module line_fill_responder
    import line_fill_responder_pkg::*;
#(
    parameter int LINE_WORDS      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_req_f_prog,
    input  logic                  is_req_f_data,
    input  logic [LINE_IDX_W-1:0] req_addr_f_prog,
    input  logic [LINE_IDX_W-1:0] req_addr_f_data,
    output logic [LINE_BITS-1:0]  read_prog_data,
    output logic [LINE_BITS-1:0]  read_data_data,
    output logic [SET_IDX_W-1:0]  read_prog_addr,
    output logic [SET_IDX_W-1:0]  read_data_addr,
    output logic                  prog_valid,
    output logic                  data_valid,
    input  logic                  fifo_empty,
    input  logic [31:0]           write_back_addr,
    input  logic [31:0]           write_back_data,
    output logic                  fifo_pop,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int ISSUE_W = $clog2(LINE_WORDS + 1);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

    fill_state_t           state_q, state_d;
    logic [LINE_IDX_W-1:0] line_idx_q;
    logic                  src_data_q;
    logic                  rr_data_q;
    logic [ISSUE_W-1:0]    issue_cnt_q;
    logic [OUT_W-1:0]      outst_q;

    logic                  pick_data;
    logic                  start_fetch;
    logic                  rd_issue;
    logic                  rd_accept;
    logic                  asm_last;
    logic [LINE_BITS-1:0]  asm_line;

`ifndef LINE_FILL_WB_DRAIN_EN
    logic unused_wb;
    assign unused_wb = ^{fifo_empty, write_back_addr, write_back_data};
`endif

    // Returns with nothing outstanding are strays (e.g. from a fetch cut
    // short by reset) and must not touch the line or the counter.
    assign rd_accept = mem_rvalid && (outst_q != '0);
    assign rd_issue  = mem_req && mem_ready && !mem_we;
    assign pick_data = (is_req_f_data && is_req_f_prog) ? rr_data_q : is_req_f_data;

    line_assembler #(
        .LINE_WORDS (LINE_WORDS)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_fetch),
        .word_valid (rd_accept),
        .word       (mem_rdata),
        .line_next  (asm_line),
        .last_word  (asm_last)
    );

    always_comb begin
        state_d     = state_q;
        start_fetch = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fifo_pop    = 1'b0;
        prog_valid  = 1'b0;
        data_valid  = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef LINE_FILL_WB_DRAIN_EN
                // Drain pending write-backs first so a fill never reads
                // stale memory behind a queued write.
                if (!fifo_empty) begin
                    state_d = WB;
                end else
`endif
                if (is_req_f_prog || is_req_f_data) begin
                    state_d     = FETCH;
                    start_fetch = 1'b1;
                end
            end
`ifdef LINE_FILL_WB_DRAIN_EN
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = write_back_addr;
                mem_wdata = write_back_data;
                if (mem_ready) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            FETCH: begin
                if ((issue_cnt_q < ISSUE_W'(LINE_WORDS)) &&
                    (outst_q < OUT_W'(MAX_OUTSTANDING))) begin
                    mem_req  = 1'b1;
                    mem_addr = {8'b0, line_idx_q, issue_cnt_q[3:0], 2'b00};
                end
                if (asm_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                prog_valid = !src_data_q;
                data_valid = src_data_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            line_idx_q     <= '0;
            src_data_q     <= 1'b0;
            rr_data_q      <= 1'b1;
            issue_cnt_q    <= '0;
            outst_q        <= '0;
            read_prog_data <= '0;
            read_data_data <= '0;
            read_prog_addr <= '0;
            read_data_addr <= '0;
        end else begin
            state_q <= state_d;

            if (start_fetch) begin
                line_idx_q  <= pick_data ? req_addr_f_data : req_addr_f_prog;
                src_data_q  <= pick_data;
                issue_cnt_q <= '0;
            end else if (rd_issue) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
            end

            if (rd_issue && !rd_accept) begin
                outst_q <= outst_q + 1'b1;
            end else if (!rd_issue && rd_accept) begin
                outst_q <= outst_q - 1'b1;
            end

            // Load the outputs on the final beat so they are stable during
            // the RESP pulse.
            if (asm_last) begin
                if (src_data_q) begin
                    read_data_data <= asm_line;
                    read_data_addr <= line_idx_q[SET_IDX_W-1:0];
                end else begin
                    read_prog_data <= asm_line;
                    read_prog_addr <= line_idx_q[SET_IDX_W-1:0];
                end
            end

            if (state_q == RESP) begin
                rr_data_q <= !src_data_q;
            end
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - directed self-checking bench for line_fill_responder
module tb_line_fill_responder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         is_req_f_prog = 1'b0;
    logic         is_req_f_data = 1'b0;
    logic [17:0]  req_addr_f_prog = '0;
    logic [17:0]  req_addr_f_data = '0;
    logic [511:0] read_prog_data, read_data_data;
    logic [7:0]   read_prog_addr, read_data_addr;
    logic         prog_valid, data_valid;
    logic         fifo_empty = 1'b1;
    logic [31:0]  write_back_addr = '0;
    logic [31:0]  write_back_data = '0;
    logic         fifo_pop;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_ready = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    line_fill_responder dut (
        .clk             (clk),
        .reset           (reset),
        .is_req_f_prog   (is_req_f_prog),
        .is_req_f_data   (is_req_f_data),
        .req_addr_f_prog (req_addr_f_prog),
        .req_addr_f_data (req_addr_f_data),
        .read_prog_data  (read_prog_data),
        .read_data_data  (read_data_data),
        .read_prog_addr  (read_prog_addr),
        .read_data_addr  (read_data_addr),
        .prog_valid      (prog_valid),
        .data_valid      (data_valid),
        .fifo_empty      (fifo_empty),
        .write_back_addr (write_back_addr),
        .write_back_data (write_back_data),
        .fifo_pop        (fifo_pop),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 1;
    int ready_mode = 0;
    logic [31:0] salt = 32'h0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;
    ret_t        rq[$];
    logic [31:0] rd_addrs[$];
    int prog_cnt = 0, data_cnt = 0, prog_cyc = 0, data_cyc = 0;
    int pop_cnt = 0, pop_cyc = 0, wr_cnt = 0, first_rd_cyc = -1;
    logic [31:0] wr_addr = '0, wr_data = '0;
    int model_out = 0, max_out = 0;

    function automatic logic [31:0] mem_fn(logic [31:0] a, logic [31:0] s);
        return {a[15:0], ~a[15:0]} ^ s;
    endfunction

    // Backing memory and bus monitor: inputs change at the falling edge,
    // outputs are observed 1 ns later, well away from the rising edge.
    always @(negedge clk) begin
        logic hs;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].data;
            void'(rq.pop_front());
        end
        mem_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
        #1;
        hs = reset && mem_req && mem_ready;
        if (!reset) begin
            model_out = 0;
        end else begin
            if (mem_rvalid && model_out > 0) model_out--;
            if (hs && !mem_we) begin
                model_out++;
                if (model_out > max_out) max_out = model_out;
                rq.push_back('{cyc + lat, mem_fn(mem_addr, salt)});
                rd_addrs.push_back(mem_addr);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (hs && mem_we) begin
                wr_cnt++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end
            if (fifo_pop)   begin pop_cnt++;  pop_cyc  = cyc; end
            if (prog_valid) begin prog_cnt++; prog_cyc = cyc; end
            if (data_valid) begin data_cnt++; data_cyc = cyc; end
        end
        cyc++;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic        is_data;
        logic [17:0] idx;
        int          lat;
        int          ready_mode;
        bit          hold;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [7:0]  exp_set;
        int          exp_lat;
    } vec_t;

    task automatic do_fill(input vec_t v, input string tag);
        int p0, d0, start, waited, errs;
        logic [511:0] exp_line, other_before;
        logic [31:0]  base;
        lat        = v.lat;
        ready_mode = v.ready_mode;
        salt       = salt + 32'h1111_0001;
        rd_addrs.delete();
        max_out = 0;
        p0 = prog_cnt;
        d0 = data_cnt;
        other_before = v.is_data ? read_prog_data : read_data_data;
        if (v.is_data) begin
            is_req_f_data = 1'b1; req_addr_f_data = v.idx;
        end else begin
            is_req_f_prog = 1'b1; req_addr_f_prog = v.idx;
        end
        start  = cyc;
        waited = 0;
        while ((v.is_data ? (data_cnt == d0) : (prog_cnt == p0)) && waited < 400) begin
            tick();
            waited++;
            if (!v.hold && waited == 3) begin
                is_req_f_data = 1'b0;
                is_req_f_prog = 1'b0;
            end
        end
        is_req_f_data = 1'b0;
        is_req_f_prog = 1'b0;
        total++;
        if (waited >= 400) begin
            bad++;
            $display("FAIL %s timeout: no valid pulse after %0d cycles", tag, waited);
        end
        check({tag, " own_pulses"}, v.is_data ? data_cnt - d0 : prog_cnt - p0, 1);
        check({tag, " other_pulses"}, v.is_data ? prog_cnt - p0 : data_cnt - d0, 0);
        if (v.exp_lat >= 0)
            check({tag, " latency"}, (v.is_data ? data_cyc : prog_cyc) - start, v.exp_lat);
        check({tag, " beats"}, rd_addrs.size(), 16);
        check({tag, " first_addr"}, rd_addrs.size() > 0 ? rd_addrs[0] : 32'hxxxx_xxxx, v.exp_first);
        check({tag, " last_addr"}, rd_addrs.size() > 0 ? rd_addrs[rd_addrs.size()-1] : 32'hxxxx_xxxx, v.exp_last);
        base = {8'b0, v.idx, 6'b0};
        errs = 0;
        foreach (rd_addrs[i]) if (rd_addrs[i] !== base + 32'(4 * i)) errs++;
        check({tag, " addr_seq_errs"}, errs, 0);
        for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = mem_fn(base + 32'(4 * k), salt);
        check({tag, " line"}, v.is_data ? read_data_data : read_prog_data, exp_line);
        check({tag, " set_addr"}, v.is_data ? read_data_addr : read_prog_addr, v.exp_set);
        check({tag, " other_held"}, v.is_data ? read_prog_data : read_data_data, other_before);
        total++;
        if (max_out > 4) begin
            bad++;
            $display("FAIL %s outstanding: got %0d want <=4", tag, max_out);
        end
        tick(8);
    endtask

    vec_t vecs[4];

    initial begin
        int p0, d0, waited;
        vec_t v;

        vecs[0] = '{1'b1, 18'h00ABC, 1, 0, 1'b1, 32'h0002_AF00, 32'h0002_AF3C, 8'hBC, 18};
        vecs[1] = '{1'b0, 18'h3FFFF, 1, 0, 1'b0, 32'h00FF_FFC0, 32'h00FF_FFFC, 8'hFF, 18};
        vecs[2] = '{1'b1, 18'h00000, 6, 1, 1'b1, 32'h0000_0000, 32'h0000_003C, 8'h00, -1};
        vecs[3] = '{1'b0, 18'h12345, 6, 0, 1'b1, 32'h0048_D140, 32'h0048_D17C, 8'h45, -1};

        tick(3);
        check("rst prog_valid", prog_valid, 0);
        check("rst data_valid", data_valid, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst fifo_pop", fifo_pop, 0);
        check("rst read_prog_data", read_prog_data, 0);
        check("rst read_data_addr", read_data_addr, 0);
        reset = 1'b1;
        tick(2);

        for (int i = 0; i < 4; i++) do_fill(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests after reset: data first, then prog.
        reset = 1'b0; tick(2); reset = 1'b1; tick(1);
        lat = 1; ready_mode = 0; salt = salt + 32'h0101_0101;
        p0 = prog_cnt; d0 = data_cnt;
        is_req_f_data = 1'b1; req_addr_f_data = 18'h01155;
        is_req_f_prog = 1'b1; req_addr_f_prog = 18'h00A66;
        waited = 0;
        while (data_cnt == d0 && prog_cnt == p0 && waited < 100) begin tick(); waited++; end
        check("rr first data", data_cnt - d0, 1);
        check("rr first no prog", prog_cnt - p0, 0);
        is_req_f_data = 1'b0;
        waited = 0;
        while (prog_cnt == p0 && waited < 100) begin tick(); waited++; end
        is_req_f_prog = 1'b0;
        tick(20);
        check("rr data pulses", data_cnt - d0, 1);
        check("rr prog pulses", prog_cnt - p0, 1);
        check("rr data set", read_data_addr, 8'h55);
        check("rr prog set", read_prog_addr, 8'h66);

        // Reset in the middle of a fill.
        lat = 1; ready_mode = 0; salt = salt + 32'h0202_0202;
        rd_addrs.delete();
        d0 = data_cnt;
        is_req_f_data = 1'b1; req_addr_f_data = 18'h00F0F;
        waited = 0;
        while (rd_addrs.size() < 8 && waited < 100) begin tick(); waited++; end
        reset = 1'b0; is_req_f_data = 1'b0;
        tick(2);
        check("midrst mem_req", mem_req, 0);
        check("midrst read_data_addr", read_data_addr, 0);
        check("midrst read_prog_data", read_prog_data, 0);
        reset = 1'b1;
        tick(15);
        check("midrst no pulse", data_cnt - d0, 0);
        v = '{1'b1, 18'h00F0F, 1, 0, 1'b1, 32'h0003_C3C0, 32'h0003_C3FC, 8'h0F, 18};
        do_fill(v, "after_rst");

`ifdef LINE_FILL_WB_DRAIN_EN
        reset = 1'b0; tick(2); reset = 1'b1; tick(1);
        lat = 1; ready_mode = 0;
        wr_cnt = 0; pop_cnt = 0; first_rd_cyc = -1; p0 = prog_cnt;
        fifo_empty = 1'b0; write_back_addr = 32'h100; write_back_data = 32'hDEADBEEF;
        is_req_f_prog = 1'b1; req_addr_f_prog = 18'h00321;
        waited = 0;
        while (pop_cnt == 0 && waited < 50) begin tick(); waited++; end
        fifo_empty = 1'b1;
        waited = 0;
        while (prog_cnt == p0 && waited < 100) begin tick(); waited++; end
        is_req_f_prog = 1'b0;
        tick(5);
        check("wb writes", wr_cnt, 1);
        check("wb addr", wr_addr, 32'h100);
        check("wb data", wr_data, 32'hDEADBEEF);
        check("wb pops", pop_cnt, 1);
        check("wb pop before read", (first_rd_cyc >= 0) && (pop_cyc < first_rd_cyc), 1);
        check("wb prog pulse", prog_cnt - p0, 1);
`else
        wr_cnt = 0; pop_cnt = 0;
        fifo_empty = 1'b0; write_back_addr = 32'h100; write_back_data = 32'hDEADBEEF;
        v = '{1'b0, 18'h00321, 1, 0, 1'b1, 32'h0000_C840, 32'h0000_C87C, 8'h21, 18};
        do_fill(v, "nowb");
        check("nowb pops", pop_cnt, 0);
        check("nowb writes", wr_cnt, 0);
        fifo_empty = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
